data_mem_responder: RTL and testbench

- Memory-side responder for the load/store path: accepts byte, halfword and word requests over a Req/Ack handshake.
- Owns a synchronous single-port 32-bit word RAM.
- Sub-word stores use read-modify-write; loads return sign- or zero-extended data.
- Sits between the datapath's load/store initiator and data storage; replaces direct RAM hookup.

---
 rtl/data_mem_responder_pkg.sv | 27 ++
 rtl/data_mem_responder_if.sv | 36 +++
 rtl/data_mem_responder_mem_lane_unit.sv | 65 ++++++
 rtl/data_mem_responder.sv | 137 +++++++++++++
 tb/tb_data_mem_responder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// Module : data_mem_responder_pkg
// Brief  : Shared size encodings, FSM states and default geometry for the
//          data memory responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package data_mem_responder_pkg;

  localparam int ADDR_W_DEF = 6;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_MERGE = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ============================================================================
// Module : data_mem_responder_if
// Brief  : Req/Ack load-store bus between initiator (master) and responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              Req;
  logic              Req_Write;
  logic [1:0]        Req_Size;
  logic              Req_Sign;
  logic [ADDR_W+1:0] Req_Addr;
  logic [31:0]       Req_WData;
  logic              Ack;
  logic              Err;
  logic [31:0]       RData;

  modport master (
    output Req, Req_Write, Req_Size, Req_Sign, Req_Addr, Req_WData,
    input  Ack, Err, RData
  );

  modport slave (
    input  Req, Req_Write, Req_Size, Req_Sign, Req_Addr, Req_WData,
    output Ack, Err, RData
  );

endinterface

`default_nettype wire

// File: rtl/data_mem_responder_mem_lane_unit.sv
// ============================================================================
// Module : mem_lane_unit
// Brief  : Combinational little-endian lane merge (stores) and lane
//          extract with sign/zero extension (loads).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_lane_unit
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        sign_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    merged_o = word_i;
    case (size_i)
      SIZE_B: begin
        case (lane_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      SIZE_H: begin
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      SIZE_W:  merged_o = wdata_i;
      default: merged_o = word_i;
    endcase
  end

  always_comb begin
    w_byte = word_i[7:0];
    case (lane_i)
      2'd0:    w_byte = word_i[7:0];
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      default: w_byte = word_i[31:24];
    endcase
    w_half = lane_i[1] ? word_i[31:16] : word_i[15:0];

    load_o = 32'd0;
    case (size_i)
      SIZE_B:  load_o = {{24{sign_i & w_byte[7]}}, w_byte};
      SIZE_H:  load_o = {{16{sign_i & w_half[15]}}, w_half};
      SIZE_W:  load_o = word_i;
      default: load_o = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module : data_mem_responder
// Brief  : Req/Ack memory responder with single-port word RAM; sub-word
//          stores via read-modify-write. Optional macro MISALIGN_TRAP_EN
//          turns misaligned halfword/word requests into errors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  data_mem_responder_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q;
  logic              ack_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rd_word_q;

  logic [ADDR_W-1:0] w_idx;
  logic              w_err;
  logic              w_we;
  logic [31:0]       w_wr_data;
  logic [31:0]       w_merged;
  logic [31:0]       w_load;

  assign w_idx = addr_q[ADDR_W+1:2];

`ifdef MISALIGN_TRAP_EN
  assign w_err = (size_q == SIZE_RSV)
               || ((size_q == SIZE_H) && addr_q[0])
               || ((size_q == SIZE_W) && (addr_q[1:0] != 2'b00));
`else
  assign w_err = (size_q == SIZE_RSV);
`endif

  // Write enable is qualified by the async-reset state, so a reset during
  // MERGE suppresses the write-back entirely.
  assign w_we = ((state_q == ST_ISSUE) && write_q && (size_q == SIZE_W) && !w_err)
              || (state_q == ST_MERGE);
  assign w_wr_data = (state_q == ST_MERGE) ? w_merged : wdata_q;

  mem_lane_unit u_lane (
    .word_i   (rd_word_q),
    .wdata_i  (wdata_q),
    .size_i   (size_q),
    .lane_i   (addr_q[1:0]),
    .sign_i   (sign_q),
    .merged_o (w_merged),
    .load_o   (w_load)
  );

  always_ff @(posedge Clk) begin
    if (w_we) begin
      mem_q[w_idx] <= w_wr_data;
    end
    if (state_q == ST_ISSUE) begin
      rd_word_q <= mem_q[w_idx];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      write_q <= 1'b0;
      size_q  <= SIZE_B;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      case (state_q)
        ST_IDLE: begin
          if (bus.Req && !ack_q) begin
            write_q <= bus.Req_Write;
            size_q  <= bus.Req_Size;
            sign_q  <= bus.Req_Sign;
            addr_q  <= bus.Req_Addr;
            wdata_q <= bus.Req_WData;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_err) begin
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (write_q && (size_q == SIZE_W)) begin
            ack_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (write_q) begin
            state_q <= ST_MERGE;
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_MERGE: begin
          ack_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_LOAD: begin
          ack_q   <= 1'b1;
          rdata_q <= w_load;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Ack   = ack_q;
  assign bus.Err   = err_q;
  assign bus.RData = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module : tb_data_mem_responder
// Brief  : Self-checking bench: directed vector table, reset-in-MERGE
//          sequence and random traffic against a byte-array memory model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int AW = 6;
  localparam int NB = 4 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(AW)) bus ();

  data_mem_responder #(.ADDR_W(AW)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mem_m [NB];

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference: the request touches 1/2/4 naturally aligned bytes.
  function automatic void model(input logic wr, input logic [1:0] size, input logic sign,
                                input logic [7:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata, output int lat);
    int n;
    int base;
    logic [31:0] v;
    err = (size == 2'b11);
`ifdef MISALIGN_TRAP_EN
    if (size == 2'b01 && addr[0]) err = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) err = 1'b1;
`endif
    rdata = 32'd0;
    if (err) begin
      lat = 2;
      return;
    end
    n = 1 << size;
    base = int'(addr) & ~(n - 1);
    if (wr) begin
      for (int i = 0; i < n; i++) mem_m[base + i] = wdata[8*i +: 8];
      lat = (n == 4) ? 2 : 3;
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[base + i];
      if (sign && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      rdata = v;
      lat = 3;
    end
  endfunction

  task automatic run_req(input logic wr, input logic [1:0] size, input logic sign,
                         input logic [7:0] addr, input logic [31:0] wdata, input bit drop_early,
                         output logic err, output logic [31:0] rdata, output int lat);
    bit got;
    bus.Req = 1'b1;  bus.Req_Write = wr;  bus.Req_Size = size;
    bus.Req_Sign = sign;  bus.Req_Addr = addr;  bus.Req_WData = wdata;
    lat = 0;
    got = 1'b0;
    err = 1'b0;
    rdata = 32'd0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (drop_early && lat == 1) begin
        bus.Req = 1'b0;  bus.Req_Addr = ~addr;
        bus.Req_WData = ~wdata;  bus.Req_Size = ~size;
      end
      if (bus.Ack) got = 1'b1;
    end
    err = bus.Err;
    rdata = bus.RData;
    bus.Req = 1'b0;
    chk("ack_seen", {31'd0, got}, 32'd1);
    if (got) begin
      @(posedge clk); #1;
      chk("ack_one_cycle", {31'd0, bus.Ack}, 32'd0);
    end
  endtask

  task automatic check_req(input string nm, input logic wr, input logic [1:0] size,
                           input logic sign, input logic [7:0] addr, input logic [31:0] wdata,
                           input bit drop_early);
    logic e_err, a_err;
    logic [31:0] e_rd, a_rd;
    int e_lat, a_lat;
    model(wr, size, sign, addr, wdata, e_err, e_rd, e_lat);
    run_req(wr, size, sign, addr, wdata, drop_early, a_err, a_rd, a_lat);
    chk({nm, "_lat"}, 32'(a_lat), 32'(e_lat));
    chk({nm, "_err"}, {31'd0, a_err}, {31'd0, e_err});
    chk({nm, "_rdata"}, a_rd, e_rd);
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sign,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata, input int lat);
    vec_t v;
    v.wr = wr; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.lat = lat;
    return v;
  endfunction

  initial begin
    vec_t vt[14];
    logic a_err, d_err;
    logic [31:0] a_rd, d_rd;
    int a_lat, d_lat;

    bus.Req = 1'b0;  bus.Req_Write = 1'b0;  bus.Req_Size = 2'b00;
    bus.Req_Sign = 1'b0;  bus.Req_Addr = '0;  bus.Req_WData = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {31'd0, bus.Ack}, 32'd0);
    chk("reset_err", {31'd0, bus.Err}, 32'd0);
    chk("reset_rdata", bus.RData, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < (1 << AW); w++)
      check_req("init", 1'b1, SIZE_W, 1'b0, 8'(w * 4), $urandom, 1'b0);

    vt[0]  = mk(1, SIZE_W, 0, 8'h04, 32'h12345678, 0, 32'h0,        2);
    vt[1]  = mk(0, SIZE_W, 0, 8'h04, 32'h0,        0, 32'h12345678, 3);
    vt[2]  = mk(1, SIZE_B, 0, 8'h05, 32'h000000AB, 0, 32'h0,        3);
    vt[3]  = mk(0, SIZE_W, 0, 8'h04, 32'h0,        0, 32'h1234AB78, 3);
    vt[4]  = mk(0, SIZE_B, 1, 8'h05, 32'h0,        0, 32'hFFFFFFAB, 3);
    vt[5]  = mk(0, SIZE_B, 0, 8'h05, 32'h0,        0, 32'h000000AB, 3);
    vt[6]  = mk(1, SIZE_H, 0, 8'h06, 32'h00008001, 0, 32'h0,        3);
    vt[7]  = mk(0, SIZE_H, 1, 8'h06, 32'h0,        0, 32'hFFFF8001, 3);
    vt[8]  = mk(0, SIZE_W, 0, 8'h04, 32'h0,        0, 32'h8001AB78, 3);
    vt[9]  = mk(1, SIZE_W, 0, 8'h00, 32'hCAFEF00D, 0, 32'h0,        2);
    vt[10] = mk(0, 2'b11,  0, 8'h00, 32'h0,        1, 32'h0,        2);
    vt[11] = mk(0, SIZE_W, 0, 8'h00, 32'h0,        0, 32'hCAFEF00D, 3);
`ifdef MISALIGN_TRAP_EN
    vt[12] = mk(0, SIZE_W, 0, 8'h02, 32'h0,        1, 32'h0,        2);
    vt[13] = mk(0, SIZE_H, 0, 8'h07, 32'h0,        1, 32'h0,        2);
`else
    vt[12] = mk(0, SIZE_W, 0, 8'h02, 32'h0,        0, 32'hCAFEF00D, 3);
    vt[13] = mk(0, SIZE_H, 0, 8'h07, 32'h0,        0, 32'h00008001, 3);
`endif

    for (int i = 0; i < 14; i++) begin
      model(vt[i].wr, vt[i].size, vt[i].sign, vt[i].addr, vt[i].wdata, d_err, d_rd, d_lat);
      run_req(vt[i].wr, vt[i].size, vt[i].sign, vt[i].addr, vt[i].wdata, 1'b0, a_err, a_rd, a_lat);
      chk($sformatf("vec%0d_lat", i), 32'(a_lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_err", i), {31'd0, a_err}, {31'd0, vt[i].err});
      chk($sformatf("vec%0d_rdata", i), a_rd, vt[i].rdata);
    end

    // Request withdrawn right after being latched must still complete.
    check_req("early_drop_ld", 1'b0, SIZE_W, 1'b0, 8'h04, 32'h0, 1'b1);
    check_req("early_drop_st", 1'b1, SIZE_B, 1'b0, 8'h09, 32'h000000C3, 1'b1);

    // Reset while the byte store sits in MERGE.
    check_req("pre_rst_st", 1'b1, SIZE_W, 1'b0, 8'h08, 32'h00000000, 1'b0);
    bus.Req = 1'b1;  bus.Req_Write = 1'b1;  bus.Req_Size = SIZE_B;
    bus.Req_Sign = 1'b0;  bus.Req_Addr = 8'h08;  bus.Req_WData = 32'h0000005A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("merge_no_ack", {31'd0, bus.Ack}, 32'd0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    bus.Req = 1'b0;
    chk("rst_mid_ack", {31'd0, bus.Ack}, 32'd0);
    chk("rst_mid_err", {31'd0, bus.Err}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(1'b0, SIZE_W, 1'b0, 8'h08, 32'h0, 1'b0, a_err, a_rd, a_lat);
    chk("post_rst_lat", 32'(a_lat), 32'd3);
    total++;
    if (a_rd !== 32'h00000000 && a_rd !== 32'h0000005A) begin
      bad++;
      $display("FAIL post_rst_word: got %h expected 00000000 or 0000005a", a_rd);
    end
    check_req("resync", 1'b1, SIZE_W, 1'b0, 8'h08, 32'h11223344, 1'b0);

    for (int i = 0; i < 400; i++)
      check_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, NB - 1)), $urandom,
                bit'($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
